// File: rtl/hermes_injector.sv
// Hermes NoC packet injector: turns a (target, size) descriptor plus a payload
// stream into a header flit followed by payload flits toward a router local port.
module hermes_injector #(
    parameter logic [15:0] ADDRESS     = 16'd0,
    parameter int          BUFFER_SIZE = 4,
    parameter int          FLIT_SIZE   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [15:0]          target_i,
    input  logic [15:0]          size_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic                 sent_o,
    output logic [15:0]          src_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]          target_q;
    logic [15:0]          size_q;
    logic [15:0]          remaining;
    logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 sent_q;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 transfer;
    logic                 desc_take;

    // Pointers wrap naturally because BUFFER_SIZE is a power of two.
    assign fifo_empty = (count == '0);
    assign pl_ready_o = (count < DEPTH);
    assign push       = pl_valid_i && pl_ready_o;
    assign transfer   = tx_o && credit_i;
    assign pop        = transfer && (state == PAYLOAD);
    assign desc_take  = desc_valid_i && (state == IDLE);
    assign sent_o     = sent_q;
    assign src_o      = ADDRESS;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        desc_ready_o = 1'b0;
        tx_o         = 1'b0;
        eop_o        = 1'b0;
        data_o       = '0;
        busy_o       = 1'b0;
        case (state)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    next_state = HEADER;
                end
            end
            HEADER: begin
                busy_o = 1'b1;
                tx_o   = 1'b1;
                data_o = {{(FLIT_SIZE-16){1'b0}}, target_q};
                eop_o  = (size_q == 16'd0);
                if (credit_i) begin
                    next_state = (size_q == 16'd0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                busy_o = 1'b1;
                // An empty FIFO is a bubble: nothing is presented, state holds.
                if (!fifo_empty) begin
                    tx_o   = 1'b1;
                    data_o = mem[rd_ptr];
                    eop_o  = (remaining == 16'd1);
                    if (credit_i && (remaining == 16'd1)) begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            target_q  <= '0;
            size_q    <= '0;
            remaining <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sent_q    <= 1'b0;
        end else begin
            sent_q <= transfer && eop_o;
            if (desc_take) begin
                target_q <= target_i;
                size_q   <= size_i;
            end
            if ((state == HEADER) && transfer) begin
                remaining <= size_q;
            end else if (pop) begin
                remaining <= remaining - 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= pl_data_i;
        end
    end

endmodule

// File: doc/hermes_injector.md
HERMES_INJECTOR -- requirements
Module: hermes_injector

Interface
REQ-001 SHALL have parameter ADDRESS, default 0, meaning the 16-bit source router address, reported on src_o.
REQ-002 SHALL have parameter BUFFER_SIZE, default 4, meaning the payload FIFO depth in flits; it is a power of 2 and at least 2.
REQ-003 SHALL have parameter FLIT_SIZE, default 32, meaning the flit width in bits; the minimum is 20.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port desc_valid_i, input, 1 bit: packet descriptor valid.
REQ-007 SHALL have port desc_ready_o, output, 1 bit: descriptor accepted when this and desc_valid_i are both 1.
REQ-008 SHALL have port target_i, input, 16 bits: destination router address.
REQ-009 SHALL have port size_i, input, 16 bits: payload flit count; 0 is legal.
REQ-010 SHALL have port pl_valid_i, input, 1 bit: payload flit valid.
REQ-011 SHALL have port pl_ready_o, output, 1 bit: payload FIFO can accept a flit.
REQ-012 SHALL have port pl_data_i, input, FLIT_SIZE bits: payload flit.
REQ-013 SHALL have port tx_o, output, 1 bit: flit valid toward the router local port.
REQ-014 SHALL have port eop_o, output, 1 bit: the current flit is the last flit of the packet.
REQ-015 SHALL have port data_o, output, FLIT_SIZE bits: flit toward the router.
REQ-016 SHALL have port credit_i, input, 1 bit: router buffer has space.
REQ-017 SHALL have port busy_o, output, 1 bit: a packet is in progress.
REQ-018 SHALL have port sent_o, output, 1 bit: one-cycle pulse after the final flit of a packet transfers.
REQ-019 SHALL have port src_o, output, 16 bits: constant ADDRESS.

Function
REQ-020 SHALL transfer a flit on a clock edge only when tx_o=1 and credit_i=1 in that cycle.
REQ-021 SHALL implement the states IDLE, HEADER and PAYLOAD.
REQ-022 SHALL drive desc_ready_o=1 only in IDLE.
REQ-023 SHALL, on descriptor acceptance, register target_i and size_i and move to HEADER on the next edge.
REQ-024 SHALL, in HEADER, drive tx_o=1 and data_o = target in bits [15:0], with bits [FLIT_SIZE-1:16] set to 0.
REQ-025 SHALL, in HEADER with the stored size=0, drive eop_o=1; on transfer it SHALL go to IDLE and pulse sent_o.
REQ-026 SHALL, in HEADER with size>0, drive eop_o=0; on transfer it SHALL load remaining=size and go to PAYLOAD.
REQ-027 SHALL, in PAYLOAD, drive tx_o = FIFO non-empty and data_o = FIFO head.
REQ-028 SHALL, in PAYLOAD, drive eop_o=1 when remaining=1 and the FIFO is non-empty.
REQ-029 SHALL, on each PAYLOAD transfer, pop the FIFO and decrement remaining; when remaining was 1 it SHALL go to IDLE and pulse sent_o on the next cycle.
REQ-030 SHALL, in PAYLOAD with an empty FIFO, drive tx_o=0 and hold the state; this is a bubble, not an error.
REQ-031 SHALL hold tx_o, data_o and eop_o stable while tx_o=1 and credit_i=0.
REQ-032 SHALL drive data_o=0 and eop_o=0 whenever tx_o=0.
REQ-033 SHALL implement the payload FIFO as a BUFFER_SIZE-entry circular buffer with wrapping read/write pointers and an occupancy count from 0 to BUFFER_SIZE.
REQ-034 SHALL drive pl_ready_o = (count < BUFFER_SIZE), derived from the registered count only.
REQ-035 SHALL NOT accept a push at full, even when a pop occurs in the same cycle.
REQ-036 SHALL accept payload in any state, including IDLE (prefetch); the stream order defines packet membership.
REQ-037 SHALL leave count unchanged on a simultaneous push and pop when not full.
REQ-038 SHALL drive busy_o=1 in HEADER and PAYLOAD.
REQ-039 SHALL NOT use size_i when no descriptor is accepted.
REQ-040 SHALL allow a new descriptor in the cycle after returning to IDLE, giving a minimum of one idle cycle between packets.

Reset
REQ-041 SHALL, while rst_i=1, asynchronously force: state IDLE, FIFO pointers and count 0, remaining 0, tx_o=0, eop_o=0, data_o=0, busy_o=0, sent_o=0, desc_ready_o=1, pl_ready_o=1.
REQ-042 SHALL, on reset mid-packet, abandon the packet and discard the FIFO contents; there is no partial-packet recovery.

Verification
REQ-043 SHALL cover: target=0x0102, size=3, payloads A,B,C prefilled, credit_i=1 -> 4 consecutive transfers 0x00000102, A, B, C; eop only on C; sent_o pulse 1 cycle later.
REQ-044 SHALL cover: size=0 -> a single header flit with eop_o=1, sent_o pulse, and back to IDLE after 2 cycles.
REQ-045 SHALL cover: size=2, credit_i=0 for 5 cycles during the header -> tx_o=1 held with data constant; transfers resume when credit_i=1.
REQ-046 SHALL cover: BUFFER_SIZE=4, 6 payload flits offered in IDLE -> pl_ready_o=0 after 4 accepted; it returns to 1 after the first pop; order is preserved across pointer wrap.
REQ-047 SHALL cover: size=3 with the 2nd payload arriving 3 cycles late -> tx_o=0 bubble, no eop, and the packet completes correctly.
REQ-048 SHALL cover: rst_i asserted after the 1st payload transfer of a size-4 packet -> all outputs are at reset values immediately, and the next packet is sent cleanly.
